// File: rtl/isa_pkg.sv
// isa_pkg: opcode map and register-usage helper shared by the hazard
// controller and its per-stage field decoder.
//   - 4-bit opcodes live in ir[3:0]; shift and ori are matched on ir[2:0].
//   - op_use() classifies an opcode into {reads R1, reads R2, writes}.
package isa_pkg;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_BNZ   = 4'b1001;
    localparam logic [3:0] OP_BPZ   = 4'b1101;

    localparam logic [2:0] OP3_ORI   = 3'b111;
    localparam logic [2:0] OP3_SHIFT = 3'b011;

    localparam int K1_IDX = 1;

    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic rd_r1;
        logic rd_r2;
        logic wr;
    } reg_use_t;

    // Branches and unassigned encodings neither read nor write registers.
    function automatic reg_use_t op_use(input logic [3:0] op);
        reg_use_t u;
        u = '0;
        if (op[2:0] == OP3_ORI || op[2:0] == OP3_SHIFT) begin
            u.rd_r1 = 1'b1;
            u.wr    = 1'b1;
        end else begin
            case (op)
                OP_LOAD:                 begin u.rd_r2 = 1'b1; u.wr = 1'b1; end
                OP_STORE:                begin u.rd_r1 = 1'b1; u.rd_r2 = 1'b1; end
                OP_ADD, OP_SUB, OP_NAND: begin u.rd_r1 = 1'b1; u.rd_r2 = 1'b1; u.wr = 1'b1; end
                default:                 u = '0;
            endcase
        end
        return u;
    endfunction

endpackage

// File: rtl/instr_regfields.sv
// instr_regfields: stateless register-field decoder for one pipeline IR.
//   ir_i      instruction word
//   rd_r1_o   instruction reads src1_o
//   rd_r2_o   instruction reads src2_o
//   src1_o    first source (R1 field, or K1 for ori)
//   src2_o    second source (R2 field)
//   wr_o      instruction writes dst_o
//   dst_o     destination register (R1 field, or K1 for ori)
module instr_regfields
    import isa_pkg::*;
#(
    parameter int IW = 8,
    parameter int RW = 2
) (
    input  logic [IW-1:0] ir_i,
    output logic          rd_r1_o,
    output logic          rd_r2_o,
    output logic [RW-1:0] src1_o,
    output logic [RW-1:0] src2_o,
    output logic          wr_o,
    output logic [RW-1:0] dst_o
);

    reg_use_t use_w;
    logic     is_ori;

    assign use_w   = op_use(ir_i[3:0]);
    assign is_ori  = (ir_i[2:0] == OP3_ORI);

    // ori implicitly targets K1 for both its read and its write.
    assign src1_o  = is_ori ? RW'(K1_IDX) : ir_i[IW-1 -: RW];
    assign src2_o  = ir_i[IW-1-RW -: RW];
    assign dst_o   = src1_o;
    assign rd_r1_o = use_w.rd_r1;
    assign rd_r2_o = use_w.rd_r2;
    assign wr_o    = use_w.wr;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: in-order pipeline controller. Owns the IR/valid shift
// chain IF..WB, stalls on RAW hazards seen at RF_STAGE, flushes younger
// stages on a taken branch at EX_STAGE, and drives PC write/select.
//   clock, reset        rising edge; synchronous active-low reset
//   instr_in/_valid     fetched instruction at current PC
//   br_taken            branch in EX is taken
//   ir_q, valid_q       flattened stage IRs (stage i at [i*IW +: IW]) and valids
//   stall, flush        combinational hazard stall / taken-branch flush
//   pc_write, pc_sel    PC enable; 0 = PC+1, 1 = branch target
//   wb_en, wb_reg       register-file write enable and destination at WB
//   stall_cnt/flush_cnt saturating event counters
module pipe_hazard_ctrl
    import isa_pkg::*;
#(
    parameter int IW        = 8,
    parameter int NREG      = 4,
    parameter int STAGES    = 5,
    parameter int RF_STAGE  = 2,
    parameter int EX_STAGE  = 3,
    parameter int WB_BYPASS = 0,
    localparam int RW       = $clog2(NREG)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [IW-1:0]        instr_in,
    input  logic                 instr_valid,
    input  logic                 br_taken,
    output logic [STAGES*IW-1:0] ir_q,
    output logic [STAGES-1:0]    valid_q,
    output logic                 stall,
    output logic                 flush,
    output logic                 pc_write,
    output logic                 pc_sel,
    output logic                 wb_en,
    output logic [RW-1:0]        wb_reg,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    // With a write-through register file the WB stage no longer conflicts.
    localparam int HZ_LAST = (WB_BYPASS != 0) ? STAGES-2 : STAGES-1;

    logic [STAGES-1:0][IW-1:0] pipe_ir_q, pipe_ir_d;
    logic [STAGES-1:0]         pipe_v_q, pipe_v_d;
    logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]          flush_cnt_q, flush_cnt_d;

    logic [STAGES-1:0]         rd1, rd2, wr;
    logic [STAGES-1:0][RW-1:0] src1, src2, dst;
    logic                      hazard;

    for (genvar g = 0; g < STAGES; g++) begin : g_dec
        instr_regfields #(.IW(IW), .RW(RW)) u_dec (
            .ir_i    (pipe_ir_q[g]),
            .rd_r1_o (rd1[g]),
            .rd_r2_o (rd2[g]),
            .src1_o  (src1[g]),
            .src2_o  (src2[g]),
            .wr_o    (wr[g]),
            .dst_o   (dst[g])
        );
    end

    // Each stage decodes every field, but only RF consumes the source side
    // and only the older stages consume the destination side.
    logic unused_dec;
    assign unused_dec = ^{rd1, rd2, src1, src2, wr, dst};

    always_comb begin
        hazard = 1'b0;
        for (int j = RF_STAGE + 1; j <= HZ_LAST; j++) begin
            if (pipe_v_q[j] && wr[j] &&
                ((rd1[RF_STAGE] && src1[RF_STAGE] == dst[j]) ||
                 (rd2[RF_STAGE] && src2[RF_STAGE] == dst[j])))
                hazard = 1'b1;
        end
        hazard = hazard & pipe_v_q[RF_STAGE];
    end

    // Flush wins: the instruction that would stall is younger than the branch.
    assign flush = pipe_v_q[EX_STAGE] & br_taken;
    assign stall = hazard & ~flush;

    always_comb begin
        pipe_ir_d = {pipe_ir_q[STAGES-2:0], instr_in};
        pipe_v_d  = {pipe_v_q[STAGES-2:0], instr_valid};
        if (stall) begin
            pipe_ir_d[RF_STAGE:0]  = pipe_ir_q[RF_STAGE:0];
            pipe_v_d[RF_STAGE:0]   = pipe_v_q[RF_STAGE:0];
            pipe_v_d[RF_STAGE+1]   = 1'b0;
        end
        // The branch itself still moves on to EX+1 as a no-op.
        if (flush)
            pipe_v_d[EX_STAGE:0] = '0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && stall_cnt_q != CNT_MAX)
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush && flush_cnt_q != CNT_MAX)
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pipe_ir_q   <= '0;
            pipe_v_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pipe_ir_q   <= pipe_ir_d;
            pipe_v_q    <= pipe_v_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ir_q      = pipe_ir_q;
    assign valid_q   = pipe_v_q;
    assign pc_write  = ~stall;
    assign pc_sel    = flush;
    assign wb_en     = pipe_v_q[STAGES-1] & wr[STAGES-1];
    assign wb_reg    = dst[STAGES-1];
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. Four instances share one stimulus stream:
// defaults, WB_BYPASS=1, STAGES=6/EX=4, and a 16-stage pipe used to reach
// counter saturation quickly. A register-set level reference model tracks
// every instance; a hand-computed vector table and short directed sequences
// pin down the default configuration.
module tb_pipe_hazard_ctrl;

    localparam int NI = 4;
    localparam int P_ST [NI] = '{5, 5, 6, 16};
    localparam int P_EX [NI] = '{3, 3, 4, 3};
    localparam int P_BY [NI] = '{0, 1, 0, 0};
    localparam int RF = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] instr_in;
    logic       instr_valid;
    logic       br_taken;

    always #5 clock = ~clock;

    logic [127:0] d_ir [NI];
    logic [15:0]  d_vq [NI];
    logic         d_st [NI], d_fl [NI], d_pw [NI], d_ps [NI], d_we [NI];
    logic [1:0]   d_wr [NI];
    logic [15:0]  d_sc [NI], d_fc [NI];

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int ST = P_ST[k];
        logic [ST*8-1:0] irq;
        logic [ST-1:0]   vq;
        logic            st, fl, pw, ps, we;
        logic [1:0]      wr;
        logic [15:0]     sc, fc;

        pipe_hazard_ctrl #(
            .IW(8), .NREG(4), .STAGES(ST), .RF_STAGE(RF),
            .EX_STAGE(P_EX[k]), .WB_BYPASS(P_BY[k])
        ) u_dut (
            .clock       (clock),
            .reset       (reset),
            .instr_in    (instr_in),
            .instr_valid (instr_valid),
            .br_taken    (br_taken),
            .ir_q        (irq),
            .valid_q     (vq),
            .stall       (st),
            .flush       (fl),
            .pc_write    (pw),
            .pc_sel      (ps),
            .wb_en       (we),
            .wb_reg      (wr),
            .stall_cnt   (sc),
            .flush_cnt   (fc)
        );

        assign d_ir[k] = 128'(irq);
        assign d_vq[k] = 16'(vq);
        assign d_st[k] = st;
        assign d_fl[k] = fl;
        assign d_pw[k] = pw;
        assign d_ps[k] = ps;
        assign d_we[k] = we;
        assign d_wr[k] = wr;
        assign d_sc[k] = sc;
        assign d_fc[k] = fc;
    end

    // ---------------- reference model ----------------
    bit         mv  [NI][16];
    logic [7:0] mir [NI][16];
    int         msc [NI];
    int         mfc [NI];

    int nchk  = 0;
    int nfail = 0;
    bit chk_en;

    // Set of registers an instruction reads, as a bitmask over k0..k3.
    function automatic logic [3:0] rd_set(input logic [7:0] i);
        logic [3:0] m;
        m = 4'b0;
        case (i[3:0])
            4'h0:                   m[i[5:4]] = 1'b1;
            4'h2, 4'h4, 4'h6, 4'h8: begin m[i[7:6]] = 1'b1; m[i[5:4]] = 1'b1; end
            4'h3, 4'hB:             m[i[7:6]] = 1'b1;
            4'h7, 4'hF:             m[1] = 1'b1;
            default:                m = 4'b0;
        endcase
        return m;
    endfunction

    // Register an instruction writes, or -1 for none.
    function automatic int wr_reg(input logic [7:0] i);
        case (i[3:0])
            4'h0, 4'h4, 4'h6, 4'h8, 4'h3, 4'hB: return int'(i[7:6]);
            4'h7, 4'hF:                         return 1;
            default:                            return -1;
        endcase
    endfunction

    function automatic bit m_haz(input int k);
        int last;
        logic [3:0] need;
        bit h;
        last = (P_BY[k] != 0) ? P_ST[k] - 2 : P_ST[k] - 1;
        need = rd_set(mir[k][RF]);
        h = 1'b0;
        for (int j = RF + 1; j <= last; j++)
            if (mv[k][j] && wr_reg(mir[k][j]) >= 0 && need[wr_reg(mir[k][j])])
                h = 1'b1;
        return h && mv[k][RF];
    endfunction

    function automatic bit m_flush(input int k);
        return mv[k][P_EX[k]] && br_taken;
    endfunction

    task automatic chk(input string nm, input int k, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s dut%0d got=%0h exp=%0h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic model_check();
        for (int k = 0; k < NI; k++) begin
            bit f, s, we;
            logic [15:0]  ev;
            logic [127:0] msk, eir;
            int ST;
            ST  = P_ST[k];
            f   = m_flush(k);
            s   = m_haz(k) && !f;
            ev  = '0;
            msk = '0;
            eir = '0;
            for (int i = 0; i < ST; i++) begin
                ev[i] = mv[k][i];
                if (mv[k][i]) begin
                    msk[i*8 +: 8] = 8'hFF;
                    eir[i*8 +: 8] = mir[k][i];
                end
            end
            we = mv[k][ST-1] && wr_reg(mir[k][ST-1]) >= 0;
            chk("m_stall", k, d_st[k], s);
            chk("m_flush", k, d_fl[k], f);
            chk("m_pc_write", k, d_pw[k], !s);
            chk("m_pc_sel", k, d_ps[k], f);
            chk("m_valid", k, d_vq[k], ev);
            chk("m_ir", k, d_ir[k] & msk, eir);
            chk("m_wb_en", k, d_we[k], we);
            if (we) chk("m_wb_reg", k, d_wr[k], wr_reg(mir[k][ST-1]));
            chk("m_stall_cnt", k, d_sc[k], msc[k]);
            chk("m_flush_cnt", k, d_fc[k], mfc[k]);
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < NI; k++) begin
            bit nv [16];
            logic [7:0] nir [16];
            bit f, s;
            int ST;
            ST = P_ST[k];
            f  = m_flush(k);
            s  = m_haz(k) && !f;
            if (!reset) begin
                for (int i = 0; i < 16; i++) begin mv[k][i] = 1'b0; mir[k][i] = 8'h00; end
                msc[k] = 0;
                mfc[k] = 0;
            end else begin
                for (int i = ST - 1; i >= 1; i--) begin nv[i] = mv[k][i-1]; nir[i] = mir[k][i-1]; end
                nv[0]  = instr_valid;
                nir[0] = instr_in;
                if (s) begin
                    for (int i = 0; i <= RF; i++) begin nv[i] = mv[k][i]; nir[i] = mir[k][i]; end
                    nv[RF+1] = 1'b0;
                end
                if (f)
                    for (int i = 0; i <= P_EX[k]; i++) nv[i] = 1'b0;
                for (int i = 0; i < ST; i++) begin mv[k][i] = nv[i]; mir[k][i] = nir[i]; end
                if (s && msc[k] < 65535) msc[k]++;
                if (f && mfc[k] < 65535) mfc[k]++;
            end
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] ins, input logic iv, input logic br);
        reset       = r;
        instr_in    = ins;
        instr_valid = iv;
        br_taken    = br;
        #1;
        if (chk_en) model_check();
    endtask

    task automatic tick();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic step(input logic r, input logic [7:0] ins, input logic iv, input logic br);
        drive(r, ins, iv, br);
        tick();
    endtask

    // ---------------- vector table (default instance) ----------------
    typedef struct {
        logic [7:0]  ins;
        logic        iv, br;
        logic [4:0]  vq;
        logic        st, fl, we;
        logic [1:0]  wr;
        logic [15:0] sc, fc;
    } vec_t;

    function automatic vec_t mkv(input int ins, input int iv, input int br, input int vq,
                                 input int st, input int fl, input int we, input int wr,
                                 input int sc, input int fc);
        vec_t v;
        v.ins = 8'(ins); v.iv = 1'(iv); v.br = 1'(br); v.vq = 5'(vq);
        v.st = 1'(st); v.fl = 1'(fl); v.we = 1'(we); v.wr = 2'(wr);
        v.sc = 16'(sc); v.fc = 16'(fc);
        return v;
    endfunction

    localparam int NV = 26;
    vec_t tbl [NV];

    initial begin
        // independent stream: load k0<-k1, store k2,k3, bz, shift k2, bnz
        tbl[0]  = mkv('h10, 1, 0, 'b00000, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mkv('hB2, 1, 0, 'b00001, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mkv('h05, 1, 0, 'b00011, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mkv('h83, 1, 0, 'b00111, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mkv('h09, 1, 0, 'b01111, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mkv('h00, 0, 0, 'b11111, 0, 0, 1, 0, 0, 0);
        tbl[6]  = mkv('h00, 0, 0, 'b11110, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mkv('h00, 0, 0, 'b11100, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mkv('h00, 0, 0, 'b11000, 0, 0, 1, 2, 0, 0);
        tbl[9]  = mkv('h00, 0, 0, 'b10000, 0, 0, 0, 0, 0, 0);
        // RAW: add k1,k2 then sub k1,k3 -> two stall cycles
        tbl[10] = mkv('h64, 1, 0, 'b00000, 0, 0, 0, 0, 0, 0);
        tbl[11] = mkv('h76, 1, 0, 'b00001, 0, 0, 0, 0, 0, 0);
        tbl[12] = mkv('h00, 0, 0, 'b00011, 0, 0, 0, 0, 0, 0);
        tbl[13] = mkv('h00, 0, 0, 'b00110, 0, 0, 0, 0, 0, 0);
        tbl[14] = mkv('h00, 0, 0, 'b01100, 1, 0, 0, 0, 0, 0);
        tbl[15] = mkv('h00, 0, 0, 'b10100, 1, 0, 1, 1, 1, 0);
        tbl[16] = mkv('h00, 0, 0, 'b00100, 0, 0, 0, 0, 2, 0);
        tbl[17] = mkv('h00, 0, 0, 'b01000, 0, 0, 0, 0, 2, 0);
        tbl[18] = mkv('h00, 0, 0, 'b10000, 0, 0, 1, 1, 2, 0);
        // taken bz at EX with three younger instructions behind it
        tbl[19] = mkv('h05, 1, 0, 'b00000, 0, 0, 0, 0, 2, 0);
        tbl[20] = mkv('h05, 1, 0, 'b00001, 0, 0, 0, 0, 2, 0);
        tbl[21] = mkv('h05, 1, 0, 'b00011, 0, 0, 0, 0, 2, 0);
        tbl[22] = mkv('h05, 1, 0, 'b00111, 0, 0, 0, 0, 2, 0);
        tbl[23] = mkv('h05, 1, 1, 'b01111, 0, 1, 0, 0, 2, 0);
        tbl[24] = mkv('h05, 1, 0, 'b10000, 0, 0, 0, 0, 2, 1);
        tbl[25] = mkv('h00, 0, 0, 'b00001, 0, 0, 0, 0, 2, 1);

        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 16; i++) begin mv[k][i] = 1'b0; mir[k][i] = 8'h00; end
            msc[k] = 0;
            mfc[k] = 0;
        end

        // reset held for two cycles
        chk_en = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk_en = 1'b1;

        for (int r = 0; r < NV; r++) begin
            drive(1'b1, tbl[r].ins, tbl[r].iv, tbl[r].br);
            if (r == 0) chk("rst_wb_reg", 0, d_wr[0], 2'd0);
            chk("t_valid", 0, d_vq[0], 16'(tbl[r].vq));
            chk("t_stall", 0, d_st[0], tbl[r].st);
            chk("t_flush", 0, d_fl[0], tbl[r].fl);
            chk("t_pc_write", 0, d_pw[0], !tbl[r].st);
            chk("t_pc_sel", 0, d_ps[0], tbl[r].fl);
            chk("t_wb_en", 0, d_we[0], tbl[r].we);
            if (tbl[r].we) chk("t_wb_reg", 0, d_wr[0], tbl[r].wr);
            chk("t_stall_cnt", 0, d_sc[0], tbl[r].sc);
            chk("t_flush_cnt", 0, d_fc[0], tbl[r].fc);
            tick();
        end

        // same RAW pair: bypass instance stalls once, 6-stage instance three times
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        chk("byp_stall_cnt", 1, d_sc[1], 16'd1);
        chk("st6_stall_cnt", 2, d_sc[2], 16'd3);
        tick();
        for (int i = 0; i < 60; i++) step(1'b1, 8'h00, 1'b0, 1'b0);

        // hazard at RF and taken branch at EX in the same cycle
        step(1'b1, 8'h64, 1'b1, 1'b0);
        step(1'b1, 8'h05, 1'b1, 1'b0);
        step(1'b1, 8'h76, 1'b1, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'h00, 1'b0, 1'b1);
        chk("s4_stall", 0, d_st[0], 1'b0);
        chk("s4_flush", 0, d_fl[0], 1'b1);
        tick();
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        chk("s4_valid", 0, d_vq[0], 16'h0010);
        chk("s4_stall_cnt", 0, d_sc[0], 16'd2);
        chk("s4_flush_cnt", 0, d_fc[0], 16'd2);
        tick();
        for (int i = 0; i < 40; i++) step(1'b1, 8'h00, 1'b0, 1'b0);

        // reset during the first stall cycle
        step(1'b1, 8'h64, 1'b1, 1'b0);
        step(1'b1, 8'h76, 1'b1, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("s5_stall", 0, d_st[0], 1'b1);
        tick();
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        chk("s5_valid", 0, d_vq[0], 16'h0000);
        chk("s5_stall_cnt", 0, d_sc[0], 16'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h00, 1'b0, 1'b0);
            chk("s5_nostall", 0, d_st[0], 1'b0);
            tick();
        end

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 600; i++) begin
            logic r, iv, br;
            logic [7:0] ins;
            r   = ($urandom_range(0, 63) != 0);
            ins = 8'($urandom);
            iv  = ($urandom_range(0, 3) != 0);
            br  = ($urandom_range(0, 3) == 0);
            step(r, ins, iv, br);
        end

        // self-dependent ori stream until the 16-stage stall counter saturates
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk_en = 1'b0;
        for (int i = 0; i < 71200; i++) step(1'b1, 8'h07, 1'b1, 1'b0);
        chk_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'h07, 1'b1, 1'b0);
            chk("sat_stall_cnt", 3, d_sc[3], 16'hFFFF);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
